// File: rtl/aes_inv_core.sv
// -----------------------------------------------------------------------------
// aes_inv_core
//   Iterative AES-128 inverse cipher, one round per clock. A cipher key is
//   expanded once, one round key per cycle, into an 11-entry round-key bank.
//   Any number of ciphertext blocks can then be decrypted with that bank,
//   applying round keys 10 down to 0.
//
// Ports
//   sclk       in   1      clock, everything on the rising edge
//   srst       in   1      synchronous active-high reset
//   key_en     in   1      pulse: capture key[] and (re)start key expansion
//   key        in   8x16   cipher key, byte 0 = FIPS-197 key[0]
//   key_ready  out  1      round-key bank is complete
//   en         in   1      pulse: start decrypting text[]
//   text       in   8x16   ciphertext, byte 0 = in[0], column-major
//   busy       out  1      decryption in progress
//   valid      out  1      one-cycle pulse, val carries a fresh plaintext
//   val        out  8x16   plaintext, held until the next completed block
//   err        out  1      only with AES_INV_ERR_EN: pulses one cycle after a
//                          dropped en or after key_en aborts a run
//
// Build option
//   AES_INV_ERR_EN  adds the err output. Without it dropped requests are silent.
//
// A new en may be presented during the final round of a block: the result
// pulse and the load of the next block share one edge, which gives an
// 11-cycle throughput with busy staying high.
// -----------------------------------------------------------------------------
module aes_inv_core (
    input  logic       sclk,
    input  logic       srst,
    input  logic       key_en,
    input  logic [7:0] key [16],
    output logic       key_ready,
    input  logic       en,
    input  logic [7:0] text [16],
    output logic       busy,
    output logic       valid,
    output logic [7:0] val [16]
`ifdef AES_INV_ERR_EN
    ,
    output logic       err
`endif
);

    // Last round-counter value (initial AddRoundKey + 10 rounds) and the
    // number of key-expansion cycles; both fixed for AES-128.
    localparam logic [3:0] ROUND_END = 4'd11;
    localparam logic [3:0] KEY_STEPS = 4'd10;

    // Byte x of a table sits at bits [2047-8x -: 8], i.e. LSB index 8*(255-x).
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] ISBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // ------------------------------------------------------------------
    // Byte-level helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        return SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return ISBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    // Multiply by 2 in GF(2^8), reduction polynomial 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] mul11(input logic [7:0] b);
        logic [7:0] x2, x8;
        x2 = xtime(b);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] mul13(input logic [7:0] b);
        logic [7:0] x4, x8;
        x4 = xtime(xtime(b));
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] mul14(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] step);
        logic [7:0] rc;
        case (step)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // One forward key-schedule step: four words in, four words out.
    function automatic logic [127:0] key_expand(input logic [127:0] prev,
                                                input logic [7:0]   rc);
        logic [31:0] w3, t, n0, n1, n2, n3;
        w3 = prev[31:0];
        t  = {sbox_fwd(w3[23:16]), sbox_fwd(w3[15:8]),
              sbox_fwd(w3[7:0]),   sbox_fwd(w3[31:24])} ^ {rc, 24'h000000};
        n0 = prev[127:96] ^ t;
        n1 = prev[95:64]  ^ n0;
        n2 = prev[63:32]  ^ n1;
        n3 = w3           ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // ------------------------------------------------------------------
    // Key FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {K_IDLE, K_EXP, K_RDY} kstate_t;

    kstate_t      kstate_reg, kstate_next;
    logic [3:0]   kstep_reg;
    logic [127:0] key_work_reg;
    logic [127:0] key_packed;
    logic [127:0] key_next;

    logic [127:0] rk_mem [11];
    logic [127:0] rk_rd_reg;
    logic         rk_we;
    logic [3:0]   rk_waddr;
    logic [127:0] rk_wdata;
    logic [3:0]   rd_addr;

    always_ff @(posedge sclk) begin
        if (srst) begin
            kstate_reg <= K_IDLE;
        end else begin
            kstate_reg <= kstate_next;
        end
    end

    always_comb begin
        kstate_next = kstate_reg;
        if (key_en) begin
            kstate_next = K_EXP;
        end else begin
            case (kstate_reg)
                K_EXP:   if (kstep_reg == KEY_STEPS) kstate_next = K_RDY;
                default: kstate_next = kstate_reg;
            endcase
        end
    end

    always_comb begin
        key_ready = (kstate_reg == K_RDY);
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            kstep_reg <= 4'd0;
        end else if (key_en) begin
            kstep_reg <= 4'd1;
        end else if (kstate_reg == K_EXP) begin
            kstep_reg <= (kstep_reg == KEY_STEPS) ? 4'd0 : kstep_reg + 4'd1;
        end
    end

    assign key_next = key_expand(key_work_reg, rcon(kstep_reg));

    // Single write port: rk0 on key_en, then one expanded key per cycle.
    always_comb begin
        rk_we    = 1'b0;
        rk_waddr = 4'd0;
        rk_wdata = key_packed;
        if (key_en) begin
            rk_we = 1'b1;
        end else if (kstate_reg == K_EXP) begin
            rk_we    = 1'b1;
            rk_waddr = kstep_reg;
            rk_wdata = key_next;
        end
    end

    // Round-key bank with registered read; the address is one round ahead
    // so the key for round n is in rk_rd_reg while round_reg == n.
    always_ff @(posedge sclk) begin
        if (rk_we) begin
            rk_mem[rk_waddr] <= rk_wdata;
            key_work_reg     <= rk_wdata;
        end
        rk_rd_reg <= rk_mem[rd_addr];
    end

    // ------------------------------------------------------------------
    // Data FSM
    // ------------------------------------------------------------------
    typedef enum logic {D_IDLE, D_RUN} dstate_t;

    dstate_t    dstate_reg, dstate_next;
    logic [3:0] round_reg;
    logic [7:0] st_reg    [16];
    logic [7:0] val_reg   [16];
    logic       valid_reg;
    logic       last_round;
    logic       accept;
    logic       finish;

    logic [7:0] rk_byte   [16];
    logic [7:0] isb       [16];
    logic [7:0] ark       [16];
    logic [7:0] first     [16];
    logic [7:0] imc       [16];
    logic [7:0] round_out [16];

    assign last_round = (dstate_reg == D_RUN) && (round_reg == ROUND_END);
    assign accept     = en && key_ready && !key_en && ((dstate_reg == D_IDLE) || last_round);
    assign finish     = last_round && !key_en;

    always_ff @(posedge sclk) begin
        if (srst) begin
            dstate_reg <= D_IDLE;
        end else begin
            dstate_reg <= dstate_next;
        end
    end

    always_comb begin
        dstate_next = dstate_reg;
        if (key_en) begin
            dstate_next = D_IDLE;
        end else if (accept) begin
            dstate_next = D_RUN;
        end else if (last_round) begin
            dstate_next = D_IDLE;
        end
    end

    always_comb begin
        busy  = (dstate_reg == D_RUN);
        valid = valid_reg;
    end

    always_comb begin
        rd_addr = 4'd0;
        if (accept) begin
            rd_addr = 4'd10;
        end else if (busy && (round_reg < 4'd10)) begin
            rd_addr = 4'd10 - round_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            // InvShiftRows: row r rotates right by r, so output (r,c)
            // comes from input (r, c-r mod 4).
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);

            assign key_packed[127-8*gi -: 8] = key[gi];
            assign rk_byte[gi] = rk_rd_reg[127-8*gi -: 8];
            assign isb[gi]     = sbox_inv(st_reg[SRC]);
            assign ark[gi]     = isb[gi] ^ rk_byte[gi];
            assign first[gi]   = st_reg[gi] ^ rk_byte[gi];
            assign val[gi]     = val_reg[gi];
        end

        for (gi = 0; gi < 4; gi++) begin : g_col
            assign imc[4*gi+0] = mul14(ark[4*gi]) ^ mul11(ark[4*gi+1]) ^
                                 mul13(ark[4*gi+2]) ^ mul9(ark[4*gi+3]);
            assign imc[4*gi+1] = mul9(ark[4*gi]) ^ mul14(ark[4*gi+1]) ^
                                 mul11(ark[4*gi+2]) ^ mul13(ark[4*gi+3]);
            assign imc[4*gi+2] = mul13(ark[4*gi]) ^ mul9(ark[4*gi+1]) ^
                                 mul14(ark[4*gi+2]) ^ mul11(ark[4*gi+3]);
            assign imc[4*gi+3] = mul11(ark[4*gi]) ^ mul13(ark[4*gi+1]) ^
                                 mul9(ark[4*gi+2]) ^ mul14(ark[4*gi+3]);
        end
    endgenerate

    // Round 1 is the bare AddRoundKey, the last round skips InvMixColumns.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            round_out[i] = imc[i];
            if (round_reg == 4'd1) begin
                round_out[i] = first[i];
            end else if (round_reg == ROUND_END) begin
                round_out[i] = ark[i];
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            round_reg <= 4'd0;
            valid_reg <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                st_reg[i]  <= 8'h00;
                val_reg[i] <= 8'h00;
            end
        end else begin
            valid_reg <= finish;
            if (finish) begin
                for (int i = 0; i < 16; i++) begin
                    val_reg[i] <= ark[i];
                end
            end
            if (key_en) begin
                round_reg <= 4'd0;
            end else if (accept) begin
                round_reg <= 4'd1;
                for (int i = 0; i < 16; i++) begin
                    st_reg[i] <= text[i];
                end
            end else if (busy) begin
                round_reg <= last_round ? 4'd0 : round_reg + 4'd1;
                for (int i = 0; i < 16; i++) begin
                    st_reg[i] <= round_out[i];
                end
            end
        end
    end

`ifdef AES_INV_ERR_EN
    logic err_reg;

    always_ff @(posedge sclk) begin
        if (srst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= (en && !accept) || (key_en && busy);
        end
    end

    assign err = err_reg;
`endif

endmodule

// File: tb/tb_aes_inv_core.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_core
//   Self-checking bench for aes_inv_core. Expected plaintexts come from the
//   FIPS-197 examples and from a behavioural inverse cipher whose S-box is
//   derived from GF(2^8) inversion plus the affine map.
// -----------------------------------------------------------------------------
module tb_aes_inv_core;

    logic       sclk = 1'b0;
    logic       srst;
    logic       key_en;
    logic [7:0] key  [16];
    logic       key_ready;
    logic       en;
    logic [7:0] text [16];
    logic       busy;
    logic       valid;
    logic [7:0] val  [16];
`ifdef AES_INV_ERR_EN
    logic       err;
`endif

    always #5 sclk = ~sclk;

    aes_inv_core dut (
        .sclk      (sclk),
        .srst      (srst),
        .key_en    (key_en),
        .key       (key),
        .key_ready (key_ready),
        .en        (en),
        .text      (text),
        .busy      (busy),
        .valid     (valid),
        .val       (val)
`ifdef AES_INV_ERR_EN
        ,
        .err       (err)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] val_p;
    always_comb begin
        val_p = '0;
        for (int i = 0; i < 16; i++) val_p[127-8*i -: 8] = val[i];
    end

    // ---------------- reference model ----------------
    logic [7:0] m_sbox  [256];
    logic [7:0] m_isbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        logic       hi;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = aa << 1;
            if (hi) aa = aa ^ 8'h1b;
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            m_sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) m_isbox[m_sbox[x]] = 8'(x);
    endtask

    // Textbook FIPS-197 InvCipher with full key schedule.
    function automatic logic [127:0] model_decrypt(input logic [127:0] k, input logic [127:0] ct);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {m_sbox[tmp[23:16]], m_sbox[tmp[15:8]], m_sbox[tmp[7:0]], m_sbox[tmp[31:24]]}
                      ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r+4*c] = s[r+4*c] ^ w[40+c][31-8*r -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c-r+4)%4)];
            for (int i = 0; i < 16; i++) s[i] = m_isbox[t[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r+4*c] = s[r+4*c] ^ w[4*rnd+c][31-8*r -: 8];
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
                    s[4*c+1] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
                    s[4*c+2] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
                    s[4*c+3] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
                end
            end
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- checks and drivers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("[TB] ok %s: %h", name, act);
        end
    endtask

    task automatic check_num(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok %s: %0d", name, act);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_key(input logic [127:0] k);
        for (int i = 0; i < 16; i++) key[i] = k[127-8*i -: 8];
    endtask

    task automatic set_text(input logic [127:0] c);
        for (int i = 0; i < 16; i++) text[i] = c[127-8*i -: 8];
    endtask

    // Called at a falling edge. Returns edges from key_en sample to key_ready
    // and the number of valid pulses seen meanwhile.
    task automatic load_key(input logic [127:0] k, output int lat, output int vcount);
        int n;
        set_key(k);
        key_en = 1'b1;
        n = 0; vcount = 0;
        while (n < 40) begin
            @(negedge sclk);
            n++;
            if (n == 1) begin key_en = 1'b0; en = 1'b0; end
            if (valid) vcount++;
            if (key_ready) break;
        end
        lat = n - 1;
    endtask

    // Called at a falling edge. Returns edges from en sample to valid and val.
    task automatic decrypt(input logic [127:0] ct, output int lat, output logic [127:0] res);
        int n;
        set_text(ct);
        en = 1'b1;
        n = 0; res = '0;
        while (n < 40) begin
            @(negedge sclk);
            n++;
            if (n == 1) en = 1'b0;
            if (valid) begin res = val_p; break; end
        end
        lat = n - 1;
    endtask

    typedef struct {
        logic [127:0] k;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int           lat, vc, n, v1, v2, blow, bseen, vseen;
        logic [127:0] res, r1, r2, ct;

        build_tables();
        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32,
                    128'h3243f6a8885a308d313198a2e0370734};
        for (int i = 2; i < 6; i++) begin
            vecs[i].k  = rand128();
            vecs[i].ct = rand128();
            vecs[i].pt = model_decrypt(vecs[i].k, vecs[i].ct);
        end

        srst = 1'b1; key_en = 1'b0; en = 1'b0;
        set_key('0); set_text('0);
        repeat (3) @(negedge sclk);
        srst = 1'b0;
        @(negedge sclk);
        check_num("reset key_ready", int'(key_ready), 0);
        check_num("reset busy", int'(busy), 0);
        check_num("reset valid", int'(valid), 0);
        check("reset val", val_p, '0);

        // en without a key: dropped
        set_text(vecs[0].ct);
        en = 1'b1;
        bseen = 0; vseen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge sclk);
            if (i == 0) begin
                en = 1'b0;
`ifdef AES_INV_ERR_EN
                check_num("err on en without key", int'(err), 1);
`endif
            end
            if (busy) bseen++;
            if (valid) vseen++;
        end
        check_num("no-key en busy cycles", bseen, 0);
        check_num("no-key en valid pulses", vseen, 0);

        // table-driven vectors
        for (int v = 0; v < 6; v++) begin
            load_key(vecs[v].k, lat, vc);
            check_num($sformatf("vec%0d key_ready latency", v), lat, 10);
            decrypt(vecs[v].ct, lat, res);
            check_num($sformatf("vec%0d valid latency", v), lat, 11);
            check($sformatf("vec%0d plaintext", v), res, vecs[v].pt);
            @(negedge sclk);
            check_num($sformatf("vec%0d valid one cycle", v), int'(valid), 0);
            check_num($sformatf("vec%0d busy after done", v), int'(busy), 0);
        end

        // several blocks under the last key, random ciphertexts
        for (int i = 0; i < 4; i++) begin
            ct = rand128();
            decrypt(ct, lat, res);
            check($sformatf("rand block %0d", i), res, model_decrypt(vecs[5].k, ct));
        end

        // key_en colliding with en: en dropped, expansion proceeds
        @(negedge sclk);
        set_text(vecs[1].ct);
        en = 1'b1;
        load_key(vecs[1].k, lat, vc);
        check_num("collision key_ready latency", lat, 10);
        check_num("collision busy", int'(busy), 0);
        check_num("collision valid pulses", vc, 0);

        // back-to-back: second en during the final round
        set_text(vecs[1].ct);
        en = 1'b1;
        n = 0; v1 = 0; v2 = 0; blow = 0; r1 = '0; r2 = '0;
        while (n < 40 && v2 == 0) begin
            @(negedge sclk);
            n++;
            if (n == 1)  en = 1'b0;
            if (n == 11) en = 1'b1;
            if (n == 12) en = 1'b0;
            if (valid) begin
                if (v1 == 0) begin v1 = n; r1 = val_p; end
                else begin v2 = n; r2 = val_p; end
            end
            if (v2 == 0 && !busy) blow++;
        end
        check_num("b2b first latency", v1 - 1, 11);
        check_num("b2b spacing", v2 - v1, 11);
        check_num("b2b busy low cycles", blow, 0);
        check("b2b first plaintext", r1, vecs[1].pt);
        check("b2b second plaintext", r2, vecs[1].pt);

        // en while busy: dropped, in-flight result intact
        @(negedge sclk);
        set_text(vecs[1].ct);
        en = 1'b1;
        n = 0; res = '0;
        while (n < 40) begin
            @(negedge sclk);
            n++;
            if (n == 1) en = 1'b0;
            if (n == 4) begin set_text(rand128()); en = 1'b1; end
            if (n == 5) begin
                en = 1'b0;
`ifdef AES_INV_ERR_EN
                check_num("err on en while busy", int'(err), 1);
`endif
            end
            if (valid) begin res = val_p; break; end
        end
        check_num("busy-en latency", n - 1, 11);
        check("busy-en plaintext", res, vecs[1].pt);

        // key_en at round 5 aborts the run
        @(negedge sclk);
        set_text(vecs[1].ct);
        en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge sclk);
            if (i == 1) en = 1'b0;
        end
        load_key(vecs[0].k, lat, vc);
        check_num("abort key_ready latency", lat, 10);
        check_num("abort valid pulses", vc, 0);
        check_num("abort busy", int'(busy), 0);
        decrypt(vecs[0].ct, lat, res);
        check("abort new-key plaintext", res, vecs[0].pt);

        // srst at round 6
        @(negedge sclk);
        set_text(vecs[0].ct);
        en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge sclk);
            if (i == 1) en = 1'b0;
        end
        srst = 1'b1;
        @(negedge sclk);
        srst = 1'b0;
        check_num("srst valid", int'(valid), 0);
        check_num("srst busy", int'(busy), 0);
        check_num("srst key_ready", int'(key_ready), 0);
        check("srst val", val_p, '0);
        en = 1'b1;
        bseen = 0; vseen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge sclk);
            if (i == 0) en = 1'b0;
            if (busy) bseen++;
            if (valid) vseen++;
        end
        check_num("post-srst en busy cycles", bseen, 0);
        check_num("post-srst en valid pulses", vseen, 0);
        load_key(vecs[1].k, lat, vc);
        check_num("post-srst key_ready latency", lat, 10);
        decrypt(vecs[1].ct, lat, res);
        check("post-srst plaintext", res, vecs[1].pt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
